// File: rtl/audio_i2s_tx_pkg.sv
// Shared constants for the serial audio transmitter.
//   FMT_I2S / FMT_LJ : values of the I2S_MODE parameter
//   SLOT_BITS        : SCLK periods per channel slot
//   SAMPLE_BITS      : width of one audio sample
package audio_i2s_tx_pkg;

  localparam int FMT_LJ      = 0;
  localparam int FMT_I2S     = 1;
  localparam int SLOT_BITS   = 32;
  localparam int SAMPLE_BITS = 16;

endpackage

// File: rtl/audio_frac_div.sv
// Fractional (phase-accumulator) divider. Adds INC every clk and wraps modulo MOD;
// tgl is high in every clk whose addition reaches MOD, giving an average strobe rate
// of clk * INC / MOD with one clk of jitter when the ratio is not an integer.
// Ports:
//   clk   in  1  system clock
//   reset in  1  synchronous, active-high; clears the accumulator
//   tgl   out 1  strobe, combinational from the accumulator state
module audio_frac_div #(
  parameter int unsigned INC = 6144000,
  parameter int unsigned MOD = 24576000
) (
  input  logic clk,
  input  logic reset,
  output logic tgl
);

  localparam logic [32:0] INC_X = 33'(INC);
  localparam logic [32:0] MOD_X = 33'(MOD);

  logic [31:0] acc;
  logic [32:0] sum;
  logic [32:0] acc_next;

  // 33-bit sum so acc + INC can never wrap before the compare.
  always_comb begin
    sum      = {1'b0, acc} + INC_X;
    tgl      = (sum >= MOD_X);
    acc_next = tgl ? (sum - MOD_X) : sum;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else begin
      acc <= acc_next[31:0];
    end
  end

endmodule

// File: rtl/audio_i2s_tx.sv
// Stereo 16-bit serial audio transmitter (I2S or left-justified, 32-bit slots).
// SCLK = 64*fs from a fractional divider; samples are latched once per frame and
// sample_ce marks that moment for the upstream filter chain.
// Ports:
//   clk       in  1   system clock
//   reset     in  1   synchronous, active-high
//   mute      in  1   transmit zeros; sampled at frame start
//   in_l      in  16  left sample, signed
//   in_r      in  16  right sample, signed
//   sample_ce out 1   one-clk pulse when in_l/in_r are latched
//   sclk      out 1   serial bit clock
//   lrclk     out 1   word select, 0 = left slot
//   sdata     out 1   serial data, updated with the SCLK falling edge
module audio_i2s_tx #(
  parameter int unsigned CLK_RATE    = 24576000,
  parameter int unsigned SAMPLE_RATE = 48000,
  parameter int          I2S_MODE    = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mute,
  input  logic signed [15:0] in_l,
  input  logic signed [15:0] in_r,
  output logic               sample_ce,
  output logic               sclk,
  output logic               lrclk,
  output logic               sdata
);

  import audio_i2s_tx_pkg::*;

  localparam int unsigned INC      = 128 * SAMPLE_RATE;
  localparam bit          IS_I2S   = (I2S_MODE == FMT_I2S);
  localparam int          BITCNT_W = $clog2(2 * SLOT_BITS);

  if (2 * longint'(INC) >= longint'(CLK_RATE)) begin : g_bad_rate
    $error("audio_i2s_tx: 128*SAMPLE_RATE must be below CLK_RATE/2");
  end

  logic                          tgl;
  logic                          fall;
  logic [BITCNT_W-1:0]           bitcnt;
  logic signed [SAMPLE_BITS-1:0] lat_l;
  logic signed [SAMPLE_BITS-1:0] lat_r;
  logic                          mute_q;
  logic                          frame_start;
  logic                          mute_eff;
  logic signed [SAMPLE_BITS-1:0] word;
  logic                          tx_bit;

  // Data bit for slot position k; I2S delays the word by one SCLK. In I2S the
  // k=0 case underflows d to 31, which falls outside the data window.
  function automatic logic slot_bit(input logic signed [SAMPLE_BITS-1:0] w,
                                    input logic [4:0] k);
    logic [4:0] d;
    logic [3:0] idx;
    d   = IS_I2S ? (k - 5'd1) : k;
    idx = 4'(SAMPLE_BITS - 1) - d[3:0];
    return (d < 5'(SAMPLE_BITS)) ? w[idx] : 1'b0;
  endfunction

  audio_frac_div #(
    .INC (INC),
    .MOD (CLK_RATE)
  ) u_div (
    .clk   (clk),
    .reset (reset),
    .tgl   (tgl)
  );

  // At the frame-start fall the latch is being loaded in the same clk, so the
  // live inputs stand in for it (matters for the LJ MSB at bit 0).
  always_comb begin
    fall        = tgl & sclk;
    frame_start = (bitcnt == '0);
    mute_eff    = frame_start ? mute : mute_q;
    word        = frame_start ? in_l : (bitcnt[5] ? lat_r : lat_l);
    tx_bit      = ~mute_eff & slot_bit(word, bitcnt[4:0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk      <= 1'b0;
      lrclk     <= 1'b0;
      sdata     <= 1'b0;
      sample_ce <= 1'b0;
      bitcnt    <= '0;
      lat_l     <= '0;
      lat_r     <= '0;
      mute_q    <= 1'b0;
    end else begin
      sample_ce <= 1'b0;
      if (tgl) begin
        sclk <= ~sclk;
      end
      if (fall) begin
        lrclk  <= bitcnt[5];
        sdata  <= tx_bit;
        bitcnt <= bitcnt + 1'b1;
        if (frame_start) begin
          lat_l     <= in_l;
          lat_r     <= in_r;
          mute_q    <= mute;
          sample_ce <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Bench for audio_i2s_tx: default I2S instance, a left-justified instance and a
// 50 MHz fractional-rate instance. Expected 64-bit frames (slot bit 0 in the MSB)
// are queued by the stimulus and compared by per-instance frame monitors.
module tb_audio_i2s_tx;

  // I2S: 0, A5C3, 15x0 | 0, 8001, 15x0
  localparam logic [63:0] E_A  = 64'h52E18000_40008000;
  // I2S: 0, 1234, 15x0 | 0, 8001, 15x0
  localparam logic [63:0] E_B  = 64'h091A0000_40008000;
  localparam logic [63:0] E_0  = 64'h0;
  // LJ: A5C3, 16x0 | 8001, 16x0
  localparam logic [63:0] E_LJ = 64'hA5C30000_80010000;

  logic clk;
  logic reset;
  logic reset2;
  logic mute;
  logic mute_fix;
  logic signed [15:0] in_l;
  logic signed [15:0] in_r;
  logic signed [15:0] fix_l;
  logic signed [15:0] fix_r;
  logic sce0, sck0, lr0, sd0;
  logic sce1, sck1, lr1, sd1;
  logic sce2, sck2, lr2, sd2;
  logic [2:0] sce_a, sck_a, sd_a, rst_a;

  int errors = 0;
  int checks = 0;
  logic [63:0] q0[$];
  logic [63:0] q1[$];

  assign sce_a = {sce2, sce1, sce0};
  assign sck_a = {sck2, sck1, sck0};
  assign sd_a  = {sd2, sd1, sd0};
  assign rst_a = {reset2, reset, reset};

  audio_i2s_tx dut (
    .clk(clk), .reset(reset), .mute(mute), .in_l(in_l), .in_r(in_r),
    .sample_ce(sce0), .sclk(sck0), .lrclk(lr0), .sdata(sd0));

  audio_i2s_tx #(.I2S_MODE(0)) dut_lj (
    .clk(clk), .reset(reset), .mute(mute_fix), .in_l(fix_l), .in_r(fix_r),
    .sample_ce(sce1), .sclk(sck1), .lrclk(lr1), .sdata(sd1));

  audio_i2s_tx #(.CLK_RATE(50000000), .SAMPLE_RATE(48000)) dut_50m (
    .clk(clk), .reset(reset2), .mute(mute_fix), .in_l(fix_l), .in_r(fix_r),
    .sample_ce(sce2), .sclk(sck2), .lrclk(lr2), .sdata(sd2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic int qsize(input int idx);
    return (idx == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [63:0] qpop(input int idx);
    if (idx == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Clks until the next default-instance sample_ce, bounded.
  task automatic wait_ce(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!sce0 && n < 2000);
    if (!sce0) begin
      checks++;
      errors++;
      $display("FAIL wait_ce: no sample_ce within %0d clk", n);
    end
  endtask

  // Collects 64 sdata bits per frame (one per SCLK fall, the first in the
  // sample_ce clk) and compares with the queued frame if one was pending.
  task automatic run_monitor(input int idx);
    logic [63:0] bits;
    logic [63:0] exp;
    int nbits;
    bit collecting;
    bit check_this;
    logic prev;
    bits = '0; nbits = 0; collecting = 0; check_this = 0; prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_a[idx]) begin
        collecting = 0;
      end else if (sce_a[idx]) begin
        chk($sformatf("ce_on_fall_%0d", idx), {63'b0, prev & ~sck_a[idx]}, 64'd1);
        if (collecting && check_this) begin
          chk($sformatf("frame_len_%0d", idx), nbits, 64);
        end
        collecting = 1;
        nbits      = 1;
        bits       = {sd_a[idx], 63'b0};
        check_this = (qsize(idx) > 0);
      end else if (collecting && prev && !sck_a[idx]) begin
        bits[63 - nbits] = sd_a[idx];
        nbits++;
        if (nbits == 64) begin
          collecting = 0;
          if (check_this) begin
            exp = qpop(idx);
            chk($sformatf("frame_dut%0d", idx), bits, exp);
          end
        end
      end
      prev = sck_a[idx];
    end
  endtask

  initial run_monitor(0);
  initial run_monitor(1);

  task automatic stim_main();
    int n;
    int lo;
    int hi;
    reset = 1'b1; mute = 1'b0;
    in_l = 16'shA5C3; in_r = 16'sh8001;
    tick(4);
    chk("rst_sclk", sck0, 1'b0);
    chk("rst_lrclk", lr0, 1'b0);
    chk("rst_sdata", sd0, 1'b0);
    chk("rst_ce", sce0, 1'b0);
    q0.push_back(E_A); q0.push_back(E_A);
    q1.push_back(E_LJ); q1.push_back(E_LJ);
    @(negedge clk) reset = 1'b0;
    wait_ce(n);
    chk("first_ce_latency", n, 8);
    // frame 1: SCLK phases, then frame period
    lo = 0;
    do begin tick(1); lo++; end while (!sck0 && lo < 50);
    hi = 0;
    do begin tick(1); hi++; end while (sck0 && hi < 50);
    chk("sclk_low", lo, 4);
    chk("sclk_high", hi, 4);
    wait_ce(n);
    chk("ce_period", lo + hi + n, 512);
    // frame 2: in_l changes mid-frame, takes effect in frame 3
    tick(100);
    in_l = 16'sh1234;
    q0.push_back(E_B);
    wait_ce(n);
    chk("ce_period2", 100 + n, 512);
    // frame 3: one-clk mute pulse mid-frame has no effect on frame 4
    tick(200);
    mute = 1'b1;
    tick(1);
    mute = 1'b0;
    q0.push_back(E_B);
    wait_ce(n);
    // frame 4: mute held across frame 5 start, released mid-frame 5
    tick(400);
    mute = 1'b1;
    q0.push_back(E_0);
    wait_ce(n);
    tick(100);
    mute = 1'b0;
    q0.push_back(E_B);
    wait_ce(n);
    wait_ce(n);
    // frame 7: at clk 270 the right MSB (1) is on sdata with sclk high
    tick(270);
    chk("pre_rst_sclk", sck0, 1'b1);
    chk("pre_rst_lrclk", lr0, 1'b1);
    chk("pre_rst_sdata", sd0, 1'b1);
    @(negedge clk) reset = 1'b1;
    tick(1);
    chk("midrst_sclk", sck0, 1'b0);
    chk("midrst_lrclk", lr0, 1'b0);
    chk("midrst_sdata", sd0, 1'b0);
    chk("midrst_ce", sce0, 1'b0);
    tick(2);
    q0.push_back(E_B);
    q1.push_back(E_LJ);
    @(negedge clk) reset = 1'b0;
    wait_ce(n);
    chk("ce_latency_after_rst", n, 8);
    wait_ce(n);
    chk("ce_period_after_rst", n, 512);
    tick(2);
  endtask

  // LJ: MSB appears in the same clk that lrclk returns 1 -> 0.
  task automatic stim_lj();
    int nce;
    int cyc;
    logic prev_lr;
    nce = 0; cyc = 0; prev_lr = 1'b0;
    fix_l = 16'shA5C3; fix_r = 16'sh8001; mute_fix = 1'b0;
    while (nce < 2 && cyc < 3000) begin
      prev_lr = lr1;
      tick(1);
      cyc++;
      if (sce1 && !reset) nce++;
    end
    chk("lj_lrclk_before", prev_lr, 1'b1);
    chk("lj_lrclk_at_ce", lr1, 1'b0);
    chk("lj_msb_at_ce", sd1, 1'b1);
  endtask

  // 50 MHz / 48 kHz: 8.14 clk per SCLK phase, 1041.67 clk per frame.
  task automatic stim_frac();
    int cnt;
    int bad;
    int phases;
    int len;
    bit first;
    logic cur;
    reset2 = 1'b1;
    tick(5);
    @(negedge clk) reset2 = 1'b0;
    cnt = 0; bad = 0; phases = 0; len = 0; first = 1;
    cur = sck2;
    repeat (20834) begin
      tick(1);
      if (sce2) cnt++;
      if (sck2 != cur) begin
        if (!first) begin
          phases++;
          if (len != 8 && len != 9) bad++;
        end
        first = 0;
        len   = 1;
        cur   = sck2;
      end else begin
        len++;
      end
    end
    chk_rng("frac_ce_count", cnt, 19, 21);
    chk("frac_bad_phases", bad, 0);
    chk_rng("frac_phases_seen", phases, 2500, 2600);
  endtask

  initial begin
    fork
      stim_main();
      stim_lj();
      stim_frac();
    join
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
